// File: rtl/fht_addr_pkg.sv
// fht_addr_pkg: FSM states, quad type and the address/twiddle helpers for the FHT sequencer.
// QW bounds MAX_LOG2 of fht_addr_gen.
package fht_addr_pkg;
  localparam int QW = 10;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  typedef logic [3:0][QW-1:0] quad_t;
  function automatic quad_t quad_of(input int t, input logic [QW-1:0] base, input logic [QW-1:0] j);
    logic [QW-1:0] h;
    h = QW'(1) << (t + 1);
    return t == 0 ? {base + QW'(3), base + QW'(2), base + QW'(1), base}
         : j == '0 ? {base + h + (h >> 1), base + (h >> 1), base + h, base}
         : {base + (h << 1) - j, base + h - j, base + h + j, base + j};
  endfunction
  function automatic logic [QW-1:0] coef_of(input logic [QW-1:0] j, input int l, input int t);
    return j << (l - 2 - t);
  endfunction
endpackage

// File: rtl/fht_addr_gen_if.sv
// fht_addr_gen_if: start request plus quad read/write address bus of the FHT sequencer.
// FHT_ADDR_STALL_EN adds the iSTALL hold input.
interface fht_addr_gen_if #(parameter int MAX_LOG2 = 10);
  localparam int LW = $clog2(MAX_LOG2 + 1);
  localparam int SW = $clog2(MAX_LOG2);
  logic iSTART;
  logic [LW-1:0] iLEN_LOG2;
`ifdef FHT_ADDR_STALL_EN
  logic iSTALL;
`endif
  logic [MAX_LOG2-1:0] oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
  logic [MAX_LOG2-1:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
  logic [MAX_LOG2-3:0] oADDR_COEF;
  logic [SW-1:0] oSTAGE;
  logic oRD_VALID, oDEGEN, oWE_A, oWE_B, oST_ZERO, oST_LAST, oRESULT_B, oERR, oRDY;
  modport master (
`ifdef FHT_ADDR_STALL_EN
    output iSTALL,
`endif
    output iSTART, iLEN_LOG2,
    input oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3, oRD_VALID, oDEGEN, oADDR_COEF,
    input oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3, oWE_A, oWE_B,
    input oST_ZERO, oST_LAST, oSTAGE, oRESULT_B, oERR, oRDY
  );
  modport slave (
`ifdef FHT_ADDR_STALL_EN
    input iSTALL,
`endif
    input iSTART, iLEN_LOG2,
    output oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3, oRD_VALID, oDEGEN, oADDR_COEF,
    output oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3, oWE_A, oWE_B,
    output oST_ZERO, oST_LAST, oSTAGE, oRESULT_B, oERR, oRDY
  );
endinterface

// File: rtl/fht_addr_delay.sv
// fht_addr_delay: LAT-deep shift register for write addresses, valid and bank; frozen while i_hold.
module fht_addr_delay #(
  parameter int W = 8,
  parameter int LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_hold,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_d
);
  logic [W-1:0] r_sr [LAT];
  always_ff @(posedge clk) begin
    if (rst) r_sr <= '{default: '0};
    else if (!i_hold) begin
      r_sr[0] <= i_d;
      for (int i = 1; i < LAT; i++) r_sr[i] <= r_sr[i-1];
    end
  end
  assign o_d = r_sr[LAT-1];
endmodule

// File: rtl/fht_addr_gen.sv
// fht_addr_gen: in-place radix-2 FHT quad address sequencer over ping-pong banks A/B.
// FHT_ADDR_STALL_EN adds iSTALL, which freezes the FSM and the write delay line.
module fht_addr_gen import fht_addr_pkg::*; #(
  parameter int MAX_LOG2 = 10,
  parameter int MIN_LOG2 = 3,
  parameter int LAT = 4
) (
  input logic iCLK,
  input logic iRESET,
  fht_addr_gen_if.slave bus
);
  localparam int AW = MAX_LOG2;
  localparam int CW = AW - 2;
  localparam int LW = $clog2(MAX_LOG2 + 1);
  localparam int SW = $clog2(MAX_LOG2);
  localparam int DW = $clog2(LAT + 1);
  state_t r_st;
  logic [LW-1:0] r_l, w_ln;
  logic [SW-1:0] r_t, w_tn;
  logic [CW-1:0] r_q, r_coef;
  logic [DW-1:0] r_dc;
  logic [QW-1:0] w_qn, w_j, w_base;
  logic [4*QW+1:0] w_dly;
  quad_t w_quad, r_rd, w_wr;
  logic r_valid, r_degen, r_z, r_last, r_res_b, r_err, r_rdy;
  logic w_hold, w_legal, w_qend, w_fin, w_load, w_wv, w_wb;
`ifdef FHT_ADDR_STALL_EN
  assign w_hold = bus.iSTALL;
`else
  assign w_hold = 1'b0;
`endif
  assign w_legal = int'(bus.iLEN_LOG2) >= MIN_LOG2 && int'(bus.iLEN_LOG2) <= MAX_LOG2;
  assign w_qend = QW'(r_q) == (QW'(1) << (int'(r_l) - 2)) - QW'(1);
  assign w_fin = int'(r_t) == int'(r_l) - 2;
  assign w_load = r_st == IDLE ? bus.iSTART && w_legal : r_st == ISSUE ? !w_qend : r_dc == '0 && !w_fin;
  assign w_ln = r_st == IDLE ? bus.iLEN_LOG2 : r_l;
  assign w_tn = r_st == DRAIN ? r_t + SW'(1) : r_st == ISSUE ? r_t : '0;
  assign w_qn = r_st == ISSUE ? QW'(r_q) + QW'(1) : '0;
  // quad index splits into group (upper bits) and j (low t bits, h/2 = 2^t per group)
  assign w_j = w_qn & ((QW'(1) << w_tn) - QW'(1));
  assign w_base = (w_qn >> w_tn) << (int'(w_tn) + 2);
  assign w_quad = quad_of(int'(w_tn), w_base, w_j);
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_st <= IDLE;
      r_l <= '0;
      r_t <= '0;
      r_q <= '0;
      r_dc <= '0;
      r_rd <= '0;
      r_coef <= '0;
      r_valid <= 1'b0;
      r_degen <= 1'b0;
      r_z <= 1'b0;
      r_last <= 1'b0;
      r_res_b <= 1'b0;
      r_err <= 1'b0;
      r_rdy <= 1'b1;
    end else if (!w_hold) begin
      r_err <= r_st == IDLE && bus.iSTART && !w_legal;
      if (w_load) begin
        r_st <= ISSUE;
        r_l <= w_ln;
        r_t <= w_tn;
        r_q <= w_qn[CW-1:0];
        r_rd <= w_quad;
        r_degen <= w_j == '0;
        r_coef <= CW'(coef_of(w_j, int'(w_ln), int'(w_tn)));
        r_z <= w_tn == '0;
        r_last <= int'(w_tn) == int'(w_ln) - 2;
        r_valid <= 1'b1;
        r_rdy <= 1'b0;
      end else if (r_st == ISSUE) begin
        r_st <= DRAIN;
        r_valid <= 1'b0;
        r_dc <= DW'(LAT - 1);
      end else if (r_st == DRAIN) begin
        if (r_dc != '0) r_dc <= r_dc - DW'(1);
        else begin
          r_st <= IDLE;
          r_rdy <= 1'b1;
          r_res_b <= ~r_t[0];
        end
      end
    end
  end
  // even stages write bank B, odd stages bank A
  fht_addr_delay #(.W(4*QW+2), .LAT(LAT)) u_dly (
    .clk(iCLK),
    .rst(iRESET),
    .i_hold(w_hold),
    .i_d({r_rd, r_valid, ~r_t[0]}),
    .o_d(w_dly)
  );
  assign w_wr = w_dly[4*QW+1:2];
  assign w_wv = w_dly[1];
  assign w_wb = w_dly[0];
  assign bus.oADDR_RD_0 = AW'(r_rd[0]);
  assign bus.oADDR_RD_1 = AW'(r_rd[1]);
  assign bus.oADDR_RD_2 = AW'(r_rd[2]);
  assign bus.oADDR_RD_3 = AW'(r_rd[3]);
  assign bus.oADDR_WR_0 = AW'(w_wr[0]);
  assign bus.oADDR_WR_1 = AW'(w_wr[1]);
  assign bus.oADDR_WR_2 = AW'(w_wr[2]);
  assign bus.oADDR_WR_3 = AW'(w_wr[3]);
  assign bus.oRD_VALID = r_valid && !w_hold;
  assign bus.oWE_A = w_wv && !w_wb && !w_hold;
  assign bus.oWE_B = w_wv && w_wb && !w_hold;
  assign bus.oDEGEN = r_degen;
  assign bus.oADDR_COEF = r_coef;
  assign bus.oST_ZERO = r_z;
  assign bus.oST_LAST = r_last;
  assign bus.oSTAGE = r_t;
  assign bus.oRESULT_B = r_res_b;
  assign bus.oERR = r_err;
  assign bus.oRDY = r_rdy;
endmodule

// File: tb/tb_fht_addr_gen.sv
// tb_fht_addr_gen: random-stimulus bench comparing fht_addr_gen against a loop-based FHT schedule model.
// With FHT_ADDR_STALL_EN defined it also drives iSTALL.
module tb_fht_addr_gen;
  localparam int ML = 10;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fht_addr_gen_if #(.MAX_LOG2(ML)) bus ();
  fht_addr_gen #(.MAX_LOG2(ML), .MIN_LOG2(3), .LAT(LAT)) dut (.iCLK(clk), .iRESET(rst), .bus(bus.slave));
  int tests = 0;
  int fails = 0;
  int cur_c = -1;
  int busy;
  logic [39:0] e_q [4096];
  logic e_v [4096];
  logic e_d [4096];
  int e_c [4096];
  int e_t [4096];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cur_c, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input int t, input int a0, input int a1, input int a2, input int a3,
                     input bit v, input bit d, input int coef);
    e_t[busy] = t;
    e_v[busy] = v;
    e_d[busy] = d;
    e_c[busy] = coef;
    e_q[busy] = {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
    busy++;
  endtask
  task automatic build(input int l);
    int n;
    n = 1 << l;
    busy = 0;
    for (int t = 0; t < l - 1; t++) begin
      int h;
      h = 1 << (t + 1);
      if (t == 0) begin
        for (int k = 0; k < n; k += 4) put(t, k, k + 1, k + 2, k + 3, 1, 1, 0);
      end else begin
        for (int b = 0; b < n; b += 2 * h)
          for (int j = 0; j < h / 2; j++)
            if (j == 0) put(t, b, b + h, b + h / 2, b + h + h / 2, 1, 1, 0);
            else put(t, b + j, b + h + j, b + h - j, b + 2 * h - j, 1, 0, j << (l - 2 - t));
      end
      for (int d = 0; d < LAT; d++) put(t, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask
  task automatic check_cycle(input int c, input int l, input bit st);
    bit wv, wb;
    cur_c = c;
    chk("rdy", bus.oRDY, 0);
    chk("err", bus.oERR, 0);
    chk("valid", bus.oRD_VALID, st ? 1'b0 : e_v[c]);
    chk("stage", bus.oSTAGE, e_t[c]);
    if (e_v[c]) begin
      chk("rd", {bus.oADDR_RD_3, bus.oADDR_RD_2, bus.oADDR_RD_1, bus.oADDR_RD_0}, e_q[c]);
      chk("degen", bus.oDEGEN, e_d[c]);
      chk("coef", bus.oADDR_COEF, e_c[c]);
      chk("stflags", {bus.oST_ZERO, bus.oST_LAST}, {e_t[c] == 0, e_t[c] == l - 2});
    end
    wv = c >= LAT && e_v[c-LAT];
    wb = c >= LAT && e_t[c-LAT] % 2 == 0;
    chk("we_b", bus.oWE_B, wv && wb && !st);
    chk("we_a", bus.oWE_A, wv && !wb && !st);
    if (wv) chk("wr", {bus.oADDR_WR_3, bus.oADDR_WR_2, bus.oADDR_WR_1, bus.oADDR_WR_0}, e_q[c-LAT]);
  endtask
  // mode 0: clean, 1: random busy starts and stalls, 2: one 3-cycle stall at cycle 5
  task automatic run(input int l, input int mode);
    int c, guard, sc;
    bit st;
    c = 0;
    guard = 0;
    sc = 0;
    build(l);
    bus.iSTART = 1'b1;
    bus.iLEN_LOG2 = 4'(l);
    tick();
    bus.iSTART = 1'b0;
    while (c < busy && guard < 8000) begin
      guard++;
      st = 1'b0;
`ifdef FHT_ADDR_STALL_EN
      st = (mode == 1 && $urandom_range(0, 15) == 0) || (mode == 2 && c == 5 && sc < 3);
      if (st) sc++;
      bus.iSTALL = st;
`endif
      if (mode == 1 && $urandom_range(0, 31) == 0) begin
        bus.iSTART = 1'b1;
        bus.iLEN_LOG2 = 4'($urandom_range(0, 15));
      end
      #1;
      check_cycle(c, l, st);
      tick();
      bus.iSTART = 1'b0;
      if (!st) c++;
    end
`ifdef FHT_ADDR_STALL_EN
    bus.iSTALL = 1'b0;
    if (mode == 2) chk("stall_cnt", sc, 3);
`endif
    cur_c = c;
    if (c < busy) chk("timeout", c, busy);
    chk("rdy_end", bus.oRDY, 1);
    chk("res_b", bus.oRESULT_B, (l - 1) % 2);
    chk("valid_end", bus.oRD_VALID, 0);
    chk("we_end", {bus.oWE_A, bus.oWE_B}, 0);
    chk("err_end", bus.oERR, 0);
  endtask
  initial begin
    int bad [4];
    bad = '{2, 11, 0, 15};
    bus.iSTART = 1'b0;
    bus.iLEN_LOG2 = '0;
`ifdef FHT_ADDR_STALL_EN
    bus.iSTALL = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_rdy", bus.oRDY, 1);
    chk("rst_valid", bus.oRD_VALID, 0);
    chk("rst_we", {bus.oWE_A, bus.oWE_B}, 0);
    chk("rst_err", bus.oERR, 0);
    chk("rst_res_b", bus.oRESULT_B, 0);
    chk("rst_stage", bus.oSTAGE, 0);
    chk("rst_rd", {bus.oADDR_RD_3, bus.oADDR_RD_2, bus.oADDR_RD_1, bus.oADDR_RD_0}, 0);
    chk("rst_wr", {bus.oADDR_WR_3, bus.oADDR_WR_2, bus.oADDR_WR_1, bus.oADDR_WR_0}, 0);
    chk("rst_misc", {bus.oDEGEN, bus.oADDR_COEF, bus.oST_ZERO, bus.oST_LAST}, 0);
    rst = 1'b0;
    tick();
    run(4, 0);
    foreach (bad[i]) begin
      bus.iSTART = 1'b1;
      bus.iLEN_LOG2 = 4'(bad[i]);
      tick();
      bus.iSTART = 1'b0;
      chk("bad_err", bus.oERR, 1);
      chk("bad_rdy", bus.oRDY, 1);
      chk("bad_valid", bus.oRD_VALID, 0);
      if (i < 3) begin
        tick();
        chk("err_pulse", bus.oERR, 0);
        chk("bad_rdy2", bus.oRDY, 1);
      end
    end
    run(10, 1);
    bus.iSTART = 1'b1;
    bus.iLEN_LOG2 = 4'd5;
    tick();
    bus.iSTART = 1'b0;
    repeat (8 + LAT + 3) tick();
    chk("mid_stage", bus.oSTAGE, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_rdy", bus.oRDY, 1);
    chk("abort_we", {bus.oWE_A, bus.oWE_B}, 0);
    chk("abort_valid", bus.oRD_VALID, 0);
    chk("abort_stage", bus.oSTAGE, 0);
    chk("abort_rd", {bus.oADDR_RD_3, bus.oADDR_RD_2, bus.oADDR_RD_1, bus.oADDR_RD_0}, 0);
    tick();
    chk("abort_we2", {bus.oWE_A, bus.oWE_B}, 0);
    run(5, 0);
    run(4, 2);
    for (int i = 0; i < 4; i++) run($urandom_range(3, 8), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
